// File: rtl/tof_readout_scheduler.sv
// Round-robin readout scheduler for eight ToF channels sharing one result mux.
// Selects a ready channel, latches its muxed result and streams it out tagged with the channel number.
module tof_readout_scheduler #(
  parameter int N_CH   = 8,
  parameter int DATA_W = 22
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_CH-1:0]     ready_in,
  input  logic [DATA_W-1:0]   data_in,
  output logic [2:0]          tof_index,
  input  logic [N_CH-1:0]     enable_mask,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [DATA_W+2:0]   m_data,
  output logic                frame_done,
  output logic [N_CH-1:0]     frame_seen
);

  typedef enum logic [1:0] {
    SCAN    = 2'd0,
    CAPTURE = 2'd1,
    SEND    = 2'd2
  } state_t;

  state_t            state_r, state_s;
  logic [2:0]        last_served_r;
  logic [N_CH-1:0]   pend_r;
  logic [N_CH-1:0]   req_s;
  logic [N_CH-1:0]   sel_oh_s;
  logic [N_CH-1:0]   cap_s;
  logic [N_CH-1:0]   pend_set_s;
  logic [N_CH-1:0]   seen_new_s;
  logic              frame_hit_s;
  logic [2:0]        pick_s;

  // First requesting channel after last_served, wrapping modulo eight.
  function automatic logic [2:0] rr_pick(input logic [N_CH-1:0] req, input logic [2:0] last);
    logic [2:0] idx;
    logic       found;
    rr_pick = last;
    found   = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      idx = last + k[2:0];
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end else begin
        found = found;
      end
    end
  endfunction

  // Request, capture and pending-set vectors.
  always_comb begin
    sel_oh_s            = {N_CH{1'b0}};
    sel_oh_s[tof_index] = 1'b1;
    req_s               = (ready_in | pend_r) & enable_mask;
    pick_s              = rr_pick(req_s, last_served_r);
    if (state_r == CAPTURE) begin
      cap_s      = sel_oh_s;
      pend_set_s = {N_CH{1'b0}};
    end else begin
      cap_s      = {N_CH{1'b0}};
      // the comm block drops ready on the parked channel, so remember it here
      pend_set_s = sel_oh_s & ready_in & enable_mask;
    end
    seen_new_s  = frame_seen | cap_s;
    frame_hit_s = (enable_mask != {N_CH{1'b0}}) && ((seen_new_s & enable_mask) == enable_mask);
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      SCAN: begin
        if (req_s != {N_CH{1'b0}}) state_s = CAPTURE;
        else                        state_s = SCAN;
      end
      CAPTURE: state_s = SEND;
      SEND: begin
        if (m_valid && m_ready) state_s = SCAN;
        else                    state_s = SEND;
      end
      default: state_s = SCAN;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_r <= SCAN;
    else       state_r <= state_s;
  end

  // Channel select, output word, pending and frame bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      tof_index     <= 3'd0;
      last_served_r <= 3'd7;
      pend_r        <= {N_CH{1'b0}};
      m_valid       <= 1'b0;
      m_data        <= {(DATA_W+3){1'b0}};
      frame_done    <= 1'b0;
      frame_seen    <= {N_CH{1'b0}};
    end else begin
      if (state_r == SCAN && req_s != {N_CH{1'b0}}) tof_index <= pick_s;
      if (state_r == CAPTURE) begin
        m_data        <= {tof_index, data_in};
        m_valid       <= 1'b1;
        last_served_r <= tof_index;
      end else if (state_r == SEND && m_valid && m_ready) begin
        m_valid <= 1'b0;
      end
      pend_r <= (pend_r | pend_set_s) & ~cap_s;
      if (frame_hit_s) begin
        frame_done <= 1'b1;
        frame_seen <= {N_CH{1'b0}};
      end else begin
        frame_done <= 1'b0;
        frame_seen <= seen_new_s & enable_mask;
      end
    end
  end

endmodule

// File: tb/tb_tof_readout_scheduler.sv
// Directed bench for tof_readout_scheduler with a small comm-block model
// (ready set on arrival, cleared one cycle after the channel is selected).
module tb_tof_readout_scheduler;
  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  ready_in;
  logic [21:0] data_in;
  logic [2:0]  tof_index;
  logic [7:0]  enable_mask;
  logic        m_valid;
  logic        m_ready;
  logic [24:0] m_data;
  logic        frame_done;
  logic [7:0]  frame_seen;

  logic [7:0]  arrive;
  logic [21:0] chan_data [8];
  logic [24:0] words [$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          fd_cnt = 0;

  always #5 clk = ~clk;

  tof_readout_scheduler dut (
    .clk(clk), .reset(reset), .ready_in(ready_in), .data_in(data_in),
    .tof_index(tof_index), .enable_mask(enable_mask), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .frame_done(frame_done),
    .frame_seen(frame_seen)
  );

  assign data_in = chan_data[tof_index];

  // comm-block ready flags
  always @(posedge clk) begin
    if (reset) ready_in <= 8'h00;
    else
      for (int i = 0; i < 8; i++)
        if (arrive[i]) ready_in[i] <= 1'b1;
        else if (tof_index == i[2:0]) ready_in[i] <= 1'b0;
  end

  // host-side view: a word counts only when valid and ready meet at an edge
  always @(posedge clk) begin
    if (!reset && m_valid && m_ready) words.push_back(m_data);
    if (!reset && frame_done) fd_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [24:0] wd(input logic [2:0] ch, input logic [21:0] d);
    return {ch, d};
  endfunction

  function automatic logic [24:0] word_at(input int idx);
    if (words.size() > idx) return words[idx];
    else return 25'h1FFFFFF;
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    arrive = 8'h00;
    tick(2);
    reset = 1'b0;
    words.delete();
    fd_cnt = 0;
  endtask

  initial begin
    reset = 1'b1; arrive = 8'h00; m_ready = 1'b1; enable_mask = 8'hFF;
    for (int i = 0; i < 8; i++) chan_data[i] = {6'(i + 8), 16'h1000 + 16'(i)};
    tick(2);
    chk("rst_tof_index", 32'(tof_index), 32'd0);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_frame_seen", 32'(frame_seen), 32'd0);
    reset = 1'b0;
    words.delete();

    // single channel latency
    chan_data[5] = 22'h02ABCD;
    arrive = 8'h20;
    tick();
    arrive = 8'h00;
    chk("single_tof_t", 32'(tof_index), 32'd0);
    tick();
    chk("single_tof_t1", 32'(tof_index), 32'd5);
    chk("single_valid_t1", 32'(m_valid), 32'd0);
    tick();
    chk("single_valid_t2", 32'(m_valid), 32'd1);
    chk("single_data", 32'(m_data), 32'({3'd5, 6'd2, 16'hABCD}));
    chk("single_seen", 32'(frame_seen), 32'h20);
    tick(3);
    chk("single_count", words.size(), 32'd1);

    // round-robin between channels 0 and 7
    do_reset();
    chan_data[0] = 22'h010001;
    chan_data[7] = 22'h3F0707;
    arrive = 8'h81;
    tick(13);
    arrive = 8'h00;
    chk("rr_w0", 32'(word_at(0)), 32'(wd(3'd0, 22'h010001)));
    chk("rr_w1", 32'(word_at(1)), 32'(wd(3'd7, 22'h3F0707)));
    chk("rr_w2", 32'(word_at(2)), 32'(wd(3'd0, 22'h010001)));
    chk("rr_w3", 32'(word_at(3)), 32'(wd(3'd7, 22'h3F0707)));
    tick(20);

    // backpressure
    m_ready = 1'b0;
    do_reset();
    chan_data[1] = 22'h051111;
    chan_data[3] = 22'h073333;
    arrive = 8'h02;
    tick();
    arrive = 8'h00;
    tick(2);
    chk("bp_valid", 32'(m_valid), 32'd1);
    arrive = 8'h08;
    tick();
    arrive = 8'h00;
    for (int i = 0; i < 10; i++) begin
      chk("bp_hold", 32'(m_data), 32'(wd(3'd1, 22'h051111)));
      tick();
    end
    chk("bp_tof_parked", 32'(tof_index), 32'd1);
    chk("bp_none_sent", words.size(), 32'd0);
    m_ready = 1'b1;
    tick(6);
    chk("bp_count", words.size(), 32'd2);
    chk("bp_w0", 32'(word_at(0)), 32'(wd(3'd1, 22'h051111)));
    chk("bp_w1", 32'(word_at(1)), 32'(wd(3'd3, 22'h073333)));

    // sample arriving on the parked channel
    m_ready = 1'b0;
    do_reset();
    chan_data[2] = 22'h0A2222;
    arrive = 8'h04;
    tick();
    arrive = 8'h00;
    tick(2);
    chk("park_tof", 32'(tof_index), 32'd2);
    chan_data[2] = 22'h0B2BBB;
    arrive = 8'h04;
    tick();
    arrive = 8'h00;
    tick(3);
    chk("park_ready_gone", 32'(ready_in[2]), 32'd0);
    m_ready = 1'b1;
    tick(6);
    chk("park_count", words.size(), 32'd2);
    chk("park_w0", 32'(word_at(0)), 32'(wd(3'd2, 22'h0A2222)));
    chk("park_w1", 32'(word_at(1)), 32'(wd(3'd2, 22'h0B2BBB)));

    // empty enable mask, then re-enable one channel
    enable_mask = 8'h00;
    do_reset();
    arrive = 8'hFF;
    tick();
    arrive = 8'h00;
    tick(10);
    chk("mask0_none", words.size(), 32'd0);
    chk("mask0_no_frame", fd_cnt, 32'd0);
    enable_mask = 8'h08;
    tick(6);
    chk("mask_reen_count", words.size(), 32'd1);
    chk("mask_reen_w0", 32'(word_at(0)), 32'(wd(3'd3, 22'h073333)));

    // frame completion over channels 0..3, channel 6 disabled
    enable_mask = 8'h0F;
    do_reset();
    arrive = 8'h4F;
    tick();
    arrive = 8'h00;
    tick(10);
    chk("frame_seen_3of4", 32'(frame_seen), 32'h07);
    chk("frame_done_early", 32'(frame_done), 32'd0);
    tick();
    chk("frame_done_pulse", 32'(frame_done), 32'd1);
    chk("frame_seen_clr", 32'(frame_seen), 32'h00);
    tick();
    chk("frame_done_drop", 32'(frame_done), 32'd0);
    tick(10);
    chk("frame_count", words.size(), 32'd4);
    chk("frame_w3", 32'(word_at(3)), 32'(wd(3'd3, 22'h073333)));
    chk("frame_pulses", fd_cnt, 32'd1);

    // reset while a word is stalled and a pending bit is set
    enable_mask = 8'hFF;
    m_ready = 1'b0;
    do_reset();
    arrive = 8'h10;
    tick();
    arrive = 8'h00;
    tick(2);
    chk("rstx_valid_before", 32'(m_valid), 32'd1);
    arrive = 8'h10;
    tick();
    arrive = 8'h00;
    tick();
    reset = 1'b1;
    tick();
    chk("rstx_valid", 32'(m_valid), 32'd0);
    chk("rstx_tof", 32'(tof_index), 32'd0);
    chk("rstx_seen", 32'(frame_seen), 32'd0);
    reset = 1'b0;
    m_ready = 1'b1;
    words.delete();
    tick(8);
    chk("rstx_pend_cleared", words.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/tof_readout_scheduler.md
Name: tof_readout_scheduler

Overview:
- Round-robin scheduler that drains the eight ToF I2C channels through their shared result mux.
- Watches the per-channel ready flags and drives the 3-bit channel select. It latches the muxed 22-bit result and emits one tagged word per sample on a valid/ready stream toward the host link.
- Tracks per-frame coverage and pulses frame_done once every enabled sensor has delivered since the last frame.

Parameters:
- N_CH, 8, number of ToF channels (select width fixed at 3 bits for 8).
- DATA_W, 22, muxed result width: {sensor_index[5:0], distance[15:0]}.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- ready_in  in  8  per-channel sample-ready flags from the comm block. Registered there, and cleared there one cycle after tof_index selects that channel with no new sample arriving.
- data_in  in  22  muxed result for the channel currently on tof_index, combinational from tof_index.
- tof_index  out  3  channel select driven to the comm block.
- enable_mask  in  8  1 = channel participates; may change at any cycle.
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream accept.
- m_data  out  25  {channel[2:0], sensor_index[5:0], distance[15:0]}.
- frame_done  out  1  one-cycle pulse when all enabled channels have been captured.
- frame_seen  out  8  channels captured in the current frame.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values:
  - state=SCAN, tof_index=0, last_served=7.
  - pend=0, m_valid=0, m_data=0.
  - frame_done=0, frame_seen=0.
- Request vector: req = (ready_in | pend) & enable_mask.
- Parked-channel protection:
  - The comm block clears ready for whichever channel is selected, so a sample on the parked channel would otherwise be lost.
  - Any cycle with ready_in[tof_index]=1, enable_mask[tof_index]=1 and state!=CAPTURE sets pend[tof_index].
  - pend[i] clears only in the CAPTURE cycle of channel i. Set and clear in the same cycle: clear wins.
- SCAN state:
  - If req=0, remain in SCAN; tof_index holds its value.
  - Otherwise pick the first set bit of req, searching last_served+1, +2, … modulo 8.
  - Register tof_index<=pick and go to CAPTURE.
- CAPTURE state (1 cycle):
  - m_data<={tof_index, data_in}, m_valid<=1, last_served<=tof_index.
  - Clear pend[tof_index], set frame_seen[tof_index], go to SEND.
  - Capture proceeds even if ready_in[tof_index] has already dropped, or if enable_mask changed meanwhile; data_in still holds that channel's latest sample.
- SEND state:
  - Hold m_data stable while m_valid=1 and m_ready=0.
  - On m_valid & m_ready: m_valid<=0 and go to SCAN.
  - tof_index stays parked throughout.
- Latency and throughput:
  - ready rise seen in SCAN at cycle t → tof_index updated at t+1 → m_valid high at t+2.
  - Maximum throughput is one word per 3 cycles with m_ready tied high.
- Frame tracking:
  - new = frame_seen | capture bit.
  - If enable_mask≠0 and (new & enable_mask)==enable_mask: frame_done=1 for exactly one cycle (the cycle after CAPTURE) and frame_seen<=0.
  - Otherwise frame_seen<=new & enable_mask. Disabling a channel drops its seen bit the next cycle.
- enable_mask=0: no captures and no frame_done. Pending bits are retained but masked; they are served if the channel is re-enabled.
- Disabled channel asserting ready: ignored, never selected, pend not set.
- Reset mid-transfer: m_valid drops the next edge, the word is discarded and all state returns to reset values. Downstream must not count a word as transferred unless m_valid & m_ready were both high at a clock edge.

Test Plan:
- Single channel: after reset, enable_mask=FF; pulse ready_in[5] with data_in=0x2_ABCD (sensor 2, distance 0xABCD) → tof_index=5 one cycle later; m_valid high 2 cycles after the ready rise with m_data={3'd5,6'd2,16'hABCD}.
- Round-robin: ready_in=0x81 held, last_served=7 → captures in channel order 0,7,0,7…; no channel is served twice in a row while the other is requesting.
- Backpressure: m_ready=0 for 10 cycles while ready_in[3] rises → m_data stable, no new capture. After m_ready=1 the word transfers, then channel 3 is captured next.
- Parked-channel sample: tof_index parked at 2 in SEND; ready_in[2] high for one cycle → pend[2] set, channel 2 served after the current word, no loss.
- Frames: enable_mask=0x0F; channels 0..3 each ready once → frame_done pulses once, after the fourth capture; frame_seen returns to 0. Channel 6 ready is never output.
- Reset during SEND with m_ready=0 → m_valid=0 and tof_index=0 the next cycle, pend=0, frame_seen=0.
